// File: rtl/hmm_seq_gen.sv
// hmm_seq_gen: hidden-Markov-model sequence generator.
// Draws a hidden-state path and an observation stream from cumulative HMM
// tables. All randomness comes from one 32-bit Galois LFSR, so a sequence
// can be reproduced exactly from its seed. Symbols leave over valid/ready.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   start, length     begin a sequence of `length` symbols (IDLE only)
//   seed_load, seed   reload the LFSR while IDLE (seed 0 loads 1)
//   cdfC/cdfA/cdfB    initial, transition and emission cumulative thresholds
//   obs_out/state_out current symbol and the hidden state that emitted it
//   obs_valid/ready   symbol handshake
//   path              hidden path; entries past `length` keep older values
//   busy, done        busy outside IDLE; done pulses once per sequence
//
// state  | meaning
// IDLE   | waiting for start, seed_load allowed
// INIT   | draw first hidden state from cdfC
// EMIT   | draw symbol from cdfB[cur], present it
// HOLD   | wait for the consumer handshake
// TRANS  | draw next hidden state from cdfA[cur]
// DONE   | sequence complete, done follows one cycle later
module hmm_seq_gen #(
  parameter int          N    = 16,
  parameter int          I    = 3,
  parameter int          K    = 3,
  parameter int          P    = 16,
  parameter logic [31:0] SEED = 32'h1,
  localparam int         LW   = $clog2(N),
  localparam int         IW   = $clog2(I),
  localparam int         KW   = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] length,
  input  logic          seed_load,
  input  logic [31:0]   seed,
  input  logic [P:0]    cdfC [I],
  input  logic [P:0]    cdfA [I][I],
  input  logic [P:0]    cdfB [I][K],
  output logic [KW-1:0] obs_out,
  output logic          obs_valid,
  input  logic          obs_ready,
  output logic [IW-1:0] state_out,
  output logic [IW-1:0] path [N],
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_EMIT, S_HOLD, S_TRANS, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_lfsr, w_lfsr_step;
  logic [LW-1:0] r_len, r_t;
  logic [IW-1:0] r_cur, w_c_sel, w_a_sel;
  logic [KW-1:0] w_b_sel;
  logic [P-1:0]  w_r;
  logic          w_draw, w_last, r_done;
  logic          w_unused_last;

  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h80200003 : 32'h0);
  assign w_last      = (r_t == r_len - LW'(1));
  assign done        = r_done;

  // Smallest index whose threshold exceeds r; the last index is the
  // fallback, so its stored threshold is never looked at.
  always_comb begin
    w_r     = r_lfsr[P-1:0];
    w_c_sel = IW'(I-1);
    w_a_sel = IW'(I-1);
    w_b_sel = KW'(K-1);
    for (int j = I-2; j >= 0; j--) begin
      if ({1'b0, w_r} < cdfC[j])        w_c_sel = IW'(j);
      if ({1'b0, w_r} < cdfA[r_cur][j]) w_a_sel = IW'(j);
    end
    for (int j = K-2; j >= 0; j--) begin
      if ({1'b0, w_r} < cdfB[r_cur][j]) w_b_sel = KW'(j);
    end
  end

  // Fold the ignored last-column thresholds into a sink.
  always_comb begin
    w_unused_last = ^cdfC[I-1];
    for (int i = 0; i < I; i++) begin
      w_unused_last = w_unused_last ^ (^cdfA[i][I-1]) ^ (^cdfB[i][K-1]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (length == '0) ? S_DONE : S_INIT;
      S_INIT:  w_state_nxt = S_EMIT;
      S_EMIT:  w_state_nxt = S_HOLD;
      S_HOLD:  if (obs_ready) w_state_nxt = w_last ? S_DONE : S_TRANS;
      S_TRANS: w_state_nxt = S_EMIT;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decoded outputs
  always_comb begin
    busy   = (r_state != S_IDLE);
    w_draw = (r_state == S_INIT) || (r_state == S_EMIT) || (r_state == S_TRANS);
  end

  // Datapath: the LFSR steps only on the three drawing states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr    <= SEED;
      r_len     <= '0;
      r_t       <= '0;
      r_cur     <= '0;
      r_done    <= 1'b0;
      obs_out   <= '0;
      obs_valid <= 1'b0;
      state_out <= '0;
      for (int n = 0; n < N; n++) path[n] <= '0;
    end else begin
      r_done <= (r_state == S_DONE);
      if ((r_state == S_IDLE) && seed_load)
        r_lfsr <= (seed == 32'h0) ? 32'h1 : seed;
      else if (w_draw)
        r_lfsr <= w_lfsr_step;
      case (r_state)
        S_IDLE:  if (start) r_len <= length;
        S_INIT: begin
          r_cur <= w_c_sel;
          r_t   <= '0;
        end
        S_EMIT: begin
          obs_out    <= w_b_sel;
          state_out  <= r_cur;
          path[r_t]  <= r_cur;
          obs_valid  <= 1'b1;
        end
        S_HOLD:  if (obs_ready) obs_valid <= 1'b0;
        S_TRANS: begin
          r_cur <= w_a_sel;
          r_t   <= r_t + LW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmm_seq_gen.sv
module tb_hmm_seq_gen;
  localparam logic [31:0] SEED = 32'h1;

  logic        clk = 1'b0;
  logic        rst, start, seed_load, obs_ready;
  logic [3:0]  length;
  logic [31:0] seed;
  logic [16:0] cdfC [3];
  logic [16:0] cdfA [3][3];
  logic [16:0] cdfB [3][3];
  logic [1:0]  obs_out, state_out;
  logic        obs_valid, busy, done;
  logic [1:0]  path [16];

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_lfsr;
  int exp_path [16];
  int m_obs[$], m_st[$];

  // observed run
  int q_obs[$], q_st[$];
  int first_valid_k, first_hs_k, last_hs_k, done_k, done_count, stall_cnt, hold_err;

  always #5 clk = ~clk;

  hmm_seq_gen #(.N(16), .I(3), .K(3), .P(16), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .seed_load(seed_load), .seed(seed),
    .cdfC(cdfC), .cdfA(cdfA), .cdfB(cdfB),
    .obs_out(obs_out), .obs_valid(obs_valid), .obs_ready(obs_ready),
    .state_out(state_out), .path(path), .busy(busy), .done(done)
  );

  // ---------------- reference model ----------------
  function automatic int rnd();
    int r;
    r = int'(m_lfsr[15:0]);
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 32'h80200003;
    else           m_lfsr = m_lfsr >> 1;
    return r;
  endfunction

  function automatic int pick(input int r, input int th0, input int th1);
    if (r < th0) return 0;
    if (r < th1) return 1;
    return 2;
  endfunction

  function automatic void model_seq(input int len);
    int cur, sym, r;
    m_obs.delete();
    m_st.delete();
    if (len == 0) return;
    r = rnd();
    cur = pick(r, int'(cdfC[0]), int'(cdfC[1]));
    for (int t = 0; t < len; t++) begin
      r = rnd();
      sym = pick(r, int'(cdfB[cur][0]), int'(cdfB[cur][1]));
      m_obs.push_back(sym);
      m_st.push_back(cur);
      exp_path[t] = cur;
      if (t < len - 1) begin
        r = rnd();
        cur = pick(r, int'(cdfA[cur][0]), int'(cdfA[cur][1]));
      end
    end
  endfunction

  function automatic int seq_errs();
    int e = 0;
    if (q_obs.size() != m_obs.size()) e++;
    for (int i = 0; i < q_obs.size() && i < m_obs.size(); i++)
      if (q_obs[i] != m_obs[i] || q_st[i] != m_st[i]) e++;
    for (int i = 0; i < 16; i++)
      if (int'(path[i]) != exp_path[i]) e++;
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0; obs_ready = 1'b0; length = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < 16; i++) exp_path[i] = 0;
  endtask

  task automatic set_ring();
    cdfC[0] = 17'h0;     cdfC[1] = 17'h10000; cdfC[2] = 17'h0;
    cdfA[0][0] = 17'h0;     cdfA[0][1] = 17'h10000; cdfA[0][2] = 17'h0;
    cdfA[1][0] = 17'h0;     cdfA[1][1] = 17'h0;     cdfA[1][2] = 17'h0;
    cdfA[2][0] = 17'h10000; cdfA[2][1] = 17'h0;     cdfA[2][2] = 17'h0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        cdfB[i][j] = (i == j) ? 17'h10000 : 17'h0;
  endtask

  task automatic rand_row(output logic [16:0] a, output logic [16:0] b, output logic [16:0] c);
    int x, y, s;
    x = $urandom_range(0, 65536);
    y = $urandom_range(0, 65536);
    if (x > y) begin s = x; x = y; y = s; end
    a = 17'(x); b = 17'(y); c = 17'($urandom_range(0, 131071));
  endtask

  task automatic rand_tables();
    rand_row(cdfC[0], cdfC[1], cdfC[2]);
    for (int i = 0; i < 3; i++) begin
      rand_row(cdfA[i][0], cdfA[i][1], cdfA[i][2]);
      rand_row(cdfB[i][0], cdfB[i][1], cdfB[i][2]);
    end
  endtask

  task automatic load_seed(input logic [31:0] s);
    @(posedge clk); #1;
    seed_load = 1'b1; seed = s;
    @(posedge clk); #1;
    seed_load = 1'b0;
    m_lfsr = (s == 32'h0) ? 32'h1 : s;
  endtask

  // mode 0: ready high; 1: 4-cycle stall on symbol index 2; 2: random ready.
  // inject: pulse start + seed_load while busy after the second handshake.
  task automatic run_seq(input int len, input int mode, input bit inject);
    bit prev_hold, injected;
    int pv_obs, pv_st;
    q_obs.delete(); q_st.delete();
    first_valid_k = -1; first_hs_k = -1; last_hs_k = -1; done_k = -1;
    done_count = 0; stall_cnt = 0; hold_err = 0;
    prev_hold = 1'b0; injected = 1'b0; pv_obs = 0; pv_st = 0;
    @(posedge clk); #1;
    start = 1'b1; length = 4'(len); obs_ready = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      @(posedge clk); #1;
      start = 1'b0; seed_load = 1'b0;
      if (done === 1'b1) begin
        done_count++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 2) break;
      if (prev_hold)
        if (!(obs_valid === 1'b1 && int'(obs_out) == pv_obs && int'(state_out) == pv_st)) hold_err++;
      case (mode)
        1:       obs_ready = !(obs_valid === 1'b1 && q_obs.size() == 2 && stall_cnt < 4);
        2:       obs_ready = 1'($urandom_range(0, 1));
        default: obs_ready = 1'b1;
      endcase
      if (mode == 1 && !obs_ready) stall_cnt++;
      prev_hold = (obs_valid === 1'b1) && !obs_ready;
      pv_obs = int'(obs_out); pv_st = int'(state_out);
      if (obs_valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
      if (obs_valid === 1'b1 && obs_ready) begin
        q_obs.push_back(int'(obs_out));
        q_st.push_back(int'(state_out));
        if (first_hs_k < 0) first_hs_k = k;
        last_hs_k = k;
      end
      if (inject && !injected && q_obs.size() == 2) begin
        start = 1'b1; length = 4'($urandom); seed_load = 1'b1; seed = $urandom;
        injected = 1'b1;
      end
    end
    obs_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pz = 0;
    do_reset();
    for (int i = 0; i < 16; i++) if (path[i] !== 2'd0) pz++;
    checks++;
    if ({obs_valid, busy, done} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl valid/busy/done=%b required=000", {obs_valid, busy, done});
    end
    checks++;
    if ({obs_out, state_out} !== 4'h0) begin
      failures++; $display("FAIL reset_data obs/state=%h required=0", {obs_out, state_out});
    end
    checks++;
    if (pz !== 0) begin
      failures++; $display("FAIL reset_path nonzero=%0d required=0", pz);
    end
  endtask

  task automatic test_ring();
    int ring [5] = '{1, 2, 0, 1, 2};
    int e, ce = 0;
    set_ring();
    model_seq(5);
    run_seq(5, 0, 1'b0);
    e = seq_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL ring_model errs=%0d required=0", e); end
    for (int i = 0; i < 5; i++) begin
      if (i >= q_obs.size() || q_obs[i] != ring[i] || int'(path[i]) != ring[i]) ce++;
    end
    checks++;
    if (ce !== 0 || q_obs.size() != 5) begin
      failures++; $display("FAIL ring_const errs=%0d count=%0d required=0/5", ce, q_obs.size());
    end
    checks++;
    if (first_valid_k !== 3) begin
      failures++; $display("FAIL ring_latency got=%0d required=3", first_valid_k);
    end
    checks++;
    if (last_hs_k - first_hs_k !== 12) begin
      failures++; $display("FAIL ring_rate span=%0d required=12", last_hs_k - first_hs_k);
    end
    checks++;
    if (done_count !== 1 || done_k !== last_hs_k + 2) begin
      failures++; $display("FAIL ring_done count=%0d at=%0d required=1 at=%0d", done_count, done_k, last_hs_k + 2);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ring_idle busy=%b required=0", busy); end
  endtask

  task automatic test_backpressure();
    int e;
    set_ring();
    model_seq(5);
    run_seq(5, 1, 1'b0);
    e = seq_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL bp_seq errs=%0d required=0", e); end
    checks++;
    if (stall_cnt !== 4 || hold_err !== 0) begin
      failures++; $display("FAIL bp_hold stalls=%0d unstable=%0d required=4/0", stall_cnt, hold_err);
    end
    checks++;
    if (last_hs_k - first_hs_k !== 16 || done_count !== 1) begin
      failures++; $display("FAIL bp_timing span=%0d done=%0d required=16/1", last_hs_k - first_hs_k, done_count);
    end
  endtask

  task automatic test_len0();
    int e;
    model_seq(0);
    run_seq(0, 0, 1'b0);
    e = seq_errs();
    checks++;
    if (done_k !== 2 || done_count !== 1) begin
      failures++; $display("FAIL len0_done at=%0d count=%0d required=2/1", done_k, done_count);
    end
    checks++;
    if (first_valid_k !== -1 || e !== 0) begin
      failures++; $display("FAIL len0_quiet valid_at=%0d errs=%0d required=-1/0", first_valid_k, e);
    end
  endtask

  task automatic test_lfsr_golden();
    int e;
    for (int i = 0; i < 3; i++) begin
      cdfC[i] = (i == 0) ? 17'h5555 : (i == 1) ? 17'hAAAA : 17'h0;
      for (int j = 0; j < 3; j++) begin
        cdfA[i][j] = (j == 0) ? 17'h5555 : (j == 1) ? 17'hAAAA : 17'h0;
        cdfB[i][j] = cdfA[i][j];
      end
    end
    load_seed(32'hACE1);
    model_seq(15);
    run_seq(15, 2, 1'b0);
    e = seq_errs();
    checks++;
    if (e !== 0 || hold_err !== 0) begin
      failures++; $display("FAIL lfsr_ace1 errs=%0d unstable=%0d required=0", e, hold_err);
    end
    load_seed(32'h0);
    model_seq(15);
    run_seq(15, 0, 1'b0);
    e = seq_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL lfsr_seed0 errs=%0d required=0", e); end
  endtask

  task automatic test_random(input int runs);
    int e, len;
    for (int n = 0; n < runs; n++) begin
      rand_tables();
      len = $urandom_range(1, 15);
      model_seq(len);
      run_seq(len, 2, 1'b0);
      e = seq_errs();
      checks++;
      if (e !== 0 || hold_err !== 0 || done_count !== 1) begin
        failures++;
        $display("FAIL random_run%0d len=%0d errs=%0d unstable=%0d done=%0d required=0/0/1", n, len, e, hold_err, done_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    rand_tables();
    model_seq(8);
    run_seq(8, 0, 1'b1);
    e = seq_errs();
    checks++;
    if (e !== 0 || done_count !== 1) begin
      failures++; $display("FAIL busy_start errs=%0d done=%0d required=0/1", e, done_count);
    end
    // an immediate second sequence continues from the undisturbed LFSR
    model_seq(6);
    run_seq(6, 0, 1'b0);
    e = seq_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL back_to_back errs=%0d required=0", e); end
  endtask

  task automatic test_reset_mid();
    int hs = 0, pz = 0, e;
    bit reached = 1'b0;
    rand_tables();
    do_reset();
    @(posedge clk); #1;
    start = 1'b1; length = 4'd10; obs_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (obs_valid === 1'b1) begin
        if (hs >= 3) begin reached = 1'b1; break; end
        hs++;
      end
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL rstmid_reach handshakes=%0d required=3", hs); end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) if (path[i] !== 2'd0) pz++;
    checks++;
    if (obs_valid !== 1'b0 || busy !== 1'b0 || pz !== 0) begin
      failures++; $display("FAIL rstmid_abort valid=%b busy=%b path_nz=%0d required=0/0/0", obs_valid, busy, pz);
    end
    @(posedge clk); #1;
    rst = 1'b0; obs_ready = 1'b0;
    m_lfsr = SEED;
    for (int i = 0; i < 16; i++) exp_path[i] = 0;
    model_seq(10);
    run_seq(10, 0, 1'b0);
    e = seq_errs();
    checks++;
    if (e !== 0) begin failures++; $display("FAIL rstmid_replay errs=%0d required=0", e); end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_backpressure();
    test_len0();
    test_random(2);
    test_lfsr_golden();
    test_random(4);
    test_back_to_back();
    test_random(2);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
